// File: rtl/apb_master_burst_n.sv
// APB3 burst master: one FIXED/INCR/WRAP command -> per-beat APB transfers on one-hot psel (APB_TIMEOUT_EN adds a pready timeout).
// Latency: 2 cycles accept->first SETUP; 3 cycles per beat (WAIT, SETUP, ACCESS) with zero-wait slaves.
// Backpressure: holds in WAIT until wr_avail/rd_space, in ACCESS until pready, in DONE until done_ready.
module apb_master_burst_n #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    LEN_WIDTH      = 8,
    parameter int                    NUM_SLAVES     = 4,
    parameter logic [ADDR_WIDTH-1:0] SLV_BASE       = 32'h0001_0000,
    parameter logic [ADDR_WIDTH-1:0] SLV_SPAN       = 32'h0001_0000,
    parameter int                    TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_avail,
    output logic                  wr_pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_space,
    output logic                  rd_push,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [1:0]            done_resp,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pwrite,
    output logic [NUM_SLAVES-1:0] psel,
    output logic                  penable,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t                state;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  slverr_q;
    logic                  decerr_q;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  unmapped;
    logic                  data_ok;
    logic                  last_beat;
    logic                  wait_end;
    logic                  apb_end;
    logic                  tmo_hit;
    logic                  dec_any;
    logic                  slv_any;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_addr;

    // Range compare in 64 bits so base + (i+1)*span cannot wrap around.
    function automatic logic [NUM_SLAVES-1:0] decode(input logic [ADDR_WIDTH-1:0] a);
        logic [NUM_SLAVES-1:0] s;
        logic [63:0]           lo;
        logic [63:0]           hi;
        s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            lo = 64'(SLV_BASE) + 64'(i) * 64'(SLV_SPAN);
            hi = lo + 64'(SLV_SPAN);
            if (64'(a) >= lo && 64'(a) < hi)
                s[i] = 1'b1;
        end
        return s;
    endfunction

    assign dec_sel   = decode(addr_q);
    assign unmapped  = (dec_sel == '0);
    assign data_ok   = write_q ? wr_avail : rd_space;
    assign last_beat = (cnt_q == len_q);
    assign wait_end  = (state == S_WAIT) && data_ok && unmapped;
    assign apb_end   = (state == S_ACCESS) && (pready || tmo_hit);
    assign dec_any   = decerr_q || wait_end;
    assign slv_any   = slverr_q || (apb_end && ((pready && pslverr) || tmo_hit));

    always_comb begin
        step      = ADDR_WIDTH'(1) << size_q;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        next_addr = addr_q + step;
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default: next_addr = addr_q + step;
        endcase
    end

    // Pop/push coincide with the completing handshake so the FIFO head has
    // already advanced when the next beat samples wr_data / wr_avail.
    assign cmd_ready  = (state == S_IDLE);
    assign done_valid = (state == S_DONE);
    assign wr_pop     = write_q && (apb_end || wait_end);
    assign rd_push    = !write_q && (apb_end || wait_end);
    assign rd_data    = (state == S_ACCESS && pready) ? prdata : '0;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    assign tmo_hit = (state == S_ACCESS) && !pready && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_q <= '0;
        else if (state != S_ACCESS || pready || tmo_hit)
            tmo_q <= '0;
        else
            tmo_q <= tmo_q + TMO_W'(1);
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            done_resp <= 2'b00;
            write_q   <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            slverr_q  <= 1'b0;
            decerr_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (cmd_valid) begin
                    write_q  <= cmd_write;
                    addr_q   <= cmd_addr;
                    len_q    <= cmd_len;
                    size_q   <= cmd_size;
                    burst_q  <= cmd_burst;
                    cnt_q    <= '0;
                    slverr_q <= 1'b0;
                    decerr_q <= 1'b0;
                    state    <= S_WAIT;
                end
                S_WAIT: if (data_ok && !unmapped) begin
                    psel   <= dec_sel;
                    paddr  <= addr_q;
                    pwrite <= write_q;
                    if (write_q)
                        pwdata <= wr_data;
                    state  <= S_SETUP;
                end
                S_SETUP: begin
                    penable <= 1'b1;
                    state   <= S_ACCESS;
                end
                S_ACCESS: if (apb_end) begin
                    psel    <= '0;
                    penable <= 1'b0;
                end
                S_DONE: if (done_ready)
                    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // Beat completion, whether through the bus or a decode miss.
            if (wait_end || apb_end) begin
                decerr_q <= dec_any;
                slverr_q <= slv_any;
                if (last_beat) begin
                    done_resp <= dec_any ? 2'b11 : (slv_any ? 2'b10 : 2'b00);
                    state     <= S_DONE;
                end else begin
                    addr_q <= next_addr;
                    cnt_q  <= cnt_q + LEN_WIDTH'(1);
                    state  <= S_WAIT;
                end
            end
        end
    end

endmodule

// File: doc/apb_master_burst_n.md
Name: apb_master_burst_n

Overview:
- Parametrised APB master engine that turns one queued burst command into a sequence of APB3 transfers, one per beat.
- Decodes each beat address onto one of NUM_SLAVES one-hot selects.
- Supports FIXED/INCR/WRAP address sequencing and reports an aggregated burst response.
- Sits between the AXI-side read/write front-ends (command plus data FIFOs) and the APB slave fabric.

Parameters:
ADDR_WIDTH, 32, address width of command and paddr
DATA_WIDTH, 32, APB data width
LEN_WIDTH, 8, beat-count width; burst is len+1 beats
NUM_SLAVES, 4, number of psel lines
SLV_BASE, 32'h0001_0000, base address of slave 0
SLV_SPAN, 32'h0001_0000, address span per slave; slave i owns [SLV_BASE+i*SLV_SPAN, SLV_BASE+(i+1)*SLV_SPAN-1]
TIMEOUT_CYCLES, 16, pready wait limit (only with APB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  engine accepts command (high only in IDLE)
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_WIDTH  start address
cmd_len  in  LEN_WIDTH  beats minus one
cmd_size  in  3  log2 bytes per beat, must be <= log2(DATA_WIDTH/8)
cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
wr_data  in  DATA_WIDTH  write-data FIFO head
wr_avail  in  1  write FIFO non-empty
wr_pop  out  1  pop write FIFO (one cycle per beat)
rd_data  out  DATA_WIDTH  read data to read FIFO
rd_space  in  1  read FIFO not full
rd_push  out  1  push rd_data (one cycle per beat)
done_valid  out  1  burst complete, response valid
done_ready  in  1  response consumed
done_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pwrite  out  1  APB direction
psel  out  NUM_SLAVES  one-hot slave select
penable  out  1  APB access phase
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset (rst_n async low): state IDLE; psel=0, penable=0, pwrite=0, paddr=0, wr_pop=0, rd_push=0, done_valid=0, done_resp=00, cmd_ready=1, beat counter=0.
- States:
  - IDLE: cmd_valid&&cmd_ready latches the command and clears the error flags -> WAIT.
  - WAIT: write needs wr_avail, read needs rd_space. If satisfied -> SETUP, else stay. Bus outputs idle while in WAIT.
  - SETUP (one cycle): psel[i] driven from decode of the current address, penable=0, paddr/pwrite/pwdata stable -> ACCESS.
  - ACCESS: penable=1 and psel held. On pready: write asserts wr_pop; read asserts rd_push with rd_data=prdata. pslverr=1 sets the SLVERR flag. Then last beat -> DONE, else advance address and counter -> WAIT. Without pready, stay in ACCESS with all outputs stable.
  - DONE: done_valid=1; holds until done_ready -> IDLE.
- Minimum latency: accept to first SETUP = 2 cycles. With zero-wait slaves, each beat costs 3 cycles (WAIT, SETUP, ACCESS).
- Unmapped address (outside all slave ranges): no psel and no APB cycle. Beat completes in WAIT as soon as data is ready: write pops and discards; read pushes rd_data=0. Sets the DECERR flag.
- Every beat is always executed; errors never shorten a burst.
- done_resp: DECERR if any unmapped beat; else SLVERR if any pslverr; else OKAY.
- Address sequencing, with step = 1<<cmd_size, all arithmetic modulo 2^ADDR_WIDTH:
  - FIXED: address unchanged.
  - INCR: addr + step.
  - WRAP: boundary = (len+1)*step, where len+1 must be 2, 4, 8 or 16. Next address = (addr & ~(boundary-1)) | ((addr + step) & (boundary-1)).
- Selected slave is re-decoded per beat, so a burst may cross slaves.
- Reset asserted mid-burst: immediate return to the reset values. No pop/push is issued, and no response is given for the aborted burst.

Optional Feature:
- APB_TIMEOUT_EN defined: a counter runs in ACCESS while pready=0. On reaching TIMEOUT_CYCLES, the beat is abandoned: psel/penable drop the next cycle, the write is popped or read data 0 is pushed, and the SLVERR flag is set. The burst then continues with the next beat.
- Not defined: ACCESS waits indefinitely for pready and the counter logic is absent.

Test Plan:
- INCR write: addr 0x0001_0000, len 3, size 2, zero-wait slave -> paddr 0x10000/0x10004/0x10008/0x1000C, psel=0001, 4 wr_pop, done_resp=00.
- WRAP read: addr 0x0002_0008, len 3, size 2 -> paddr 0x20008/0x2000C/0x20000/0x20004, psel=0010, 4 rd_push carrying prdata.
- pslverr asserted on beat 1 of a 3-beat write -> all 3 beats issued, done_resp=10. Then done_ready held low 5 cycles -> done_valid held, cmd_ready=0.
- Unmapped read: addr 0x0000_1000, len 1 -> psel never asserted, 2 rd_push of 0, done_resp=11.
- Backpressure: rd_space low for 4 cycles before beat 2 -> engine stays in WAIT, psel=0. pready low for 3 ACCESS cycles -> paddr/psel/penable stable.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready stuck low -> beat abandoned after 16 cycles, done_resp=10. Reset mid-burst -> all outputs return to reset values within the same cycle.
